// File: rtl/fetch_queue.sv
// Fetch-to-Decode instruction buffer: in-order circular queue with valid/ready on both sides.
// Optional same-cycle bypass into an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [ADDR_WIDTH-1:2]         in_addr,
  input  logic [31:0]                   in_insn,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [ADDR_WIDTH-1:2]         out_addr,
  output logic [31:0]                   out_insn,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          overflow
);

  localparam int INSN_WIDTH = 32;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int CNT_W      = $clog2(DEPTH+1);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [ADDR_WIDTH-1:2] addr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:2] addr_mem_d [DEPTH];
  logic [INSN_WIDTH-1:0] insn_mem_q [DEPTH];
  logic [INSN_WIDTH-1:0] insn_mem_d [DEPTH];

  logic full, empty, push, pop, byp_take;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;
  assign overflow = overflow_q;

  // Queue pop only ever advances rd_ptr on a real stored entry.
  assign pop = !empty && out_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  assign byp       = empty && in_valid && !flush;
  assign byp_take  = byp && out_ready;
  assign out_valid = !empty || byp;
  assign out_addr  = byp ? in_addr : addr_mem_q[rd_ptr_q];
  assign out_insn  = byp ? in_insn : insn_mem_q[rd_ptr_q];
`else
  assign byp_take  = 1'b0;
  assign out_valid = !empty;
  assign out_addr  = addr_mem_q[rd_ptr_q];
  assign out_insn  = insn_mem_q[rd_ptr_q];
`endif

  // A bypassed entry that Decode takes immediately is never stored.
  assign push = in_valid && in_ready && !flush && !byp_take;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    addr_mem_d = addr_mem_q;
    insn_mem_d = insn_mem_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        addr_mem_d[wr_ptr_q] = in_addr;
        insn_mem_d[wr_ptr_q] = in_insn;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (in_valid && full && !flush) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        insn_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      addr_mem_q <= addr_mem_d;
      insn_mem_q <= insn_mem_d;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the Fetch stage and the Decode stage.
- Captures each fetched {instruction address, instruction word} pair and presents them to Decode in order, using a valid/ready handshake.
- Gives Fetch a backpressure signal and discards all buffered instructions on a backend redirect.
- Storage is a circular buffer of DEPTH entries, with a 1-cycle fill latency by default.

Parameters:
- ADDR_WIDTH, 32: byte-address width. Instruction addresses are carried as [ADDR_WIDTH-1:2] because instructions are 4-byte aligned.
- DEPTH, 4: number of entries. Must be a power of 2 and at least 2.
- Fixed localparams: INSN_WIDTH = 32, PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1).

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- rst, input, 1: asynchronous, active-low reset (0 = in reset).
- flush, input, 1: backend redirect; discards all entries.
- in_valid, input, 1: Fetch presents an instruction.
- in_addr, input, ADDR_WIDTH-2: instruction address [ADDR_WIDTH-1:2].
- in_insn, input, 32: instruction word.
- in_ready, output, 1: queue can accept a write this cycle.
- out_valid, output, 1: head entry valid for Decode.
- out_addr, output, ADDR_WIDTH-2: head entry address.
- out_insn, output, 32: head entry instruction.
- out_ready, input, 1: Decode accepts the head entry.
- count, output, CNT_W: current occupancy.
- overflow, output, 1: sticky error flag, set when a write is attempted while full.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Outputs: out_valid=0, in_ready=1.
  - out_addr and out_insn read the storage head, which is cleared to 0.
- Derived signals:
  - in_ready = (count != DEPTH), a function of registered state only.
  - out_valid = (count != 0).
  - out_addr and out_insn = storage[rd_ptr], a combinational read of registered storage.
- Push condition: in_valid & in_ready & !flush.
  - Write storage[wr_ptr], then wr_ptr += 1.
  - Pointers wrap modulo DEPTH through natural PTR_W overflow.
- Pop condition: out_valid & out_ready & !flush. Action: rd_ptr += 1.
- Count update:
  - Push only: count += 1.
  - Pop only: count -= 1.
  - Push and pop together: count unchanged.
- Latency: an entry pushed at edge N appears on out_* in the cycle after edge N, so fill latency is 1 cycle.
- Full (count == DEPTH):
  - in_ready=0.
  - No push occurs, even if a pop happens in the same cycle; there is no same-cycle pass-through when full.
  - in_ready rises in the cycle after the pop.
- Empty (count == 0): out_valid=0, and out_ready is ignored.
- Overflow: if in_valid=1 while in_ready=0 and flush=0:
  - The write is dropped and storage is unchanged.
  - overflow is set to 1 at the next edge.
  - overflow is cleared only by reset.
- Flush has the highest priority and is synchronous:
  - At the edge: wr_ptr=0, rd_ptr=0, count=0.
  - Any push or pop in the same cycle is discarded.
  - out_valid=0 in the next cycle.
  - Storage contents are not cleared.
  - overflow is unaffected.
- Reset asserted mid-operation immediately returns all state to the reset values. The first push is accepted at the first edge after rst rises.
- Order is strictly FIFO. No entry is duplicated or reordered across pointer wrap.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- When defined, bypass applies if count==0 and in_valid=1 and flush=0:
  - out_valid=1 and out_addr/out_insn = in_addr/in_insn in the same cycle (0-cycle latency).
  - If out_ready=1, the entry is consumed and not written; count stays 0.
  - If out_ready=0, the entry is written normally and count becomes 1.
  - in_ready and overflow behaviour are unchanged.
- When undefined: behaviour is exactly as in Behaviour, with 1-cycle latency always.

Test Plan:
- Reset then single push: rst low 2 cycles then high; push addr=0x100>>2, insn=0x00000013, out_ready=1 -> out_valid=1 next cycle with those values; count goes 1 then 0.
- Fill without pop, DEPTH=4, out_ready=0: 4 pushes -> count=4, in_ready=0. A 5th in_valid -> dropped, overflow=1, and contents are unchanged.
- Full with simultaneous pop and in_valid: no push that cycle, count=3 -> in_ready=1 the next cycle, and the next push lands at the correct pointer.
- Wrap: stream 10 sequential instructions (insn = 0x1000+i) with out_ready toggling 1,0,1,... -> Decode receives all 10 in order with no loss and no duplicates.
- Flush: with count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0. A following push appears alone at the head.
- Async reset mid-stream: with count=2, drive rst=0 between clock edges -> out_valid=0, count=0, in_ready=1 immediately, without waiting for an edge. Bypass build only: push into the empty queue with out_ready=1 -> out_valid=1 in the same cycle and count stays 0.
